// File: rtl/digit_timer_n_if.sv
// Control and status bundle of the multi-digit BCD countdown timer.
// The master side is the tick generator / controller; the slave side is the timer.
interface digit_timer_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    reconfig;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    zero;
  logic                    done;
  logic                    stall;

  modport master (
    output reconfig, load, load_val, tick,
    input  count, zero, done, stall
  );

  modport slave (
    input  reconfig, load, load_val, tick,
    output count, zero, done, stall
  );
endinterface

// File: rtl/digit_timer_n.sv
// Multi-digit mixed-radix BCD countdown timer with load, auto-reload, done and stall pulses.
//   state      | meaning
//   ST_RUNNING | count != 0, ticks decrement with internal borrow
//   ST_EXPIRED | count == 0, ticks hold (stall) or restart from reload_q
module digit_timer_n #(
  parameter int                      NUM_DIGITS  = 4,
  parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX   = 16'h5959,
  parameter logic [4*NUM_DIGITS-1:0] RESET_VAL   = 16'h5959,
  parameter bit                      AUTO_RELOAD = 1'b0
) (
  input logic             clk,
  input logic             rst,
  digit_timer_n_if.slave  tif
);

  localparam int W = 4*NUM_DIGITS;

  typedef enum logic {ST_RUNNING, ST_EXPIRED} state_t;
  typedef enum logic [2:0] {OP_IDLE, OP_RECONFIG, OP_LOAD, OP_DEC, OP_AT_ZERO} op_t;

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic [W-1:0] clamped;
  logic [W-1:0] decremented;
  logic         done_q, done_d;
  logic         stall_q, stall_d;
  state_t       state;
  op_t          op;

  always_comb begin
    state = (count_q == '0) ? ST_EXPIRED : ST_RUNNING;
  end

  // Out-of-range nibbles (including A-F) saturate to the digit's maximum.
  always_comb begin
    clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (tif.load_val[4*i +: 4] > DIGIT_MAX[4*i +: 4])
        clamped[4*i +: 4] = DIGIT_MAX[4*i +: 4];
      else
        clamped[4*i +: 4] = tif.load_val[4*i +: 4];
    end
  end

  // Ripple borrow from digit 0 upward; zero digits wrap to their maximum.
  always_comb begin : dec_blk
    logic borrow;
    borrow      = 1'b1;
    decremented = count_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          decremented[4*i +: 4] = DIGIT_MAX[4*i +: 4];
        end else begin
          decremented[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow                = 1'b0;
        end
      end
    end
  end

  always_comb begin
    op = OP_IDLE;
    if (tif.reconfig)
      op = OP_RECONFIG;
    else if (tif.load)
      op = OP_LOAD;
    else if (tif.tick)
      op = (state == ST_RUNNING) ? OP_DEC : OP_AT_ZERO;
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    stall_d  = 1'b0;
    case (op)
      OP_RECONFIG: count_d = reload_q;
      OP_LOAD: begin
        count_d  = clamped;
        reload_d = clamped;
      end
      OP_DEC: begin
        count_d = decremented;
        done_d  = (decremented == '0);
      end
      OP_AT_ZERO: begin
        if (AUTO_RELOAD)
          count_d = reload_q;
        else
          stall_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
      done_q   <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      stall_q  <= stall_d;
    end
  end

  assign tif.count = count_q;
  assign tif.zero  = (state == ST_EXPIRED);
  assign tif.done  = done_q;
  assign tif.stall = stall_q;

endmodule

// File: tb/tb_digit_timer_n.sv
// Bench for digit_timer_n: MM:SS instances with and without auto-reload, checked
// against a mixed-radix integer model, a vector table and hand-written sequences.
module tb_digit_timer_n;

  localparam int MAXD[4] = '{9, 5, 9, 5};

  logic        clk;
  logic        rst;
  logic        reconfig, load, tick;
  logic [15:0] load_val;

  int n_err = 0;
  int n_chk = 0;

  digit_timer_n_if #(.NUM_DIGITS(4)) if0 ();
  digit_timer_n_if #(.NUM_DIGITS(4)) if1 ();

  assign if0.reconfig = reconfig;
  assign if0.load     = load;
  assign if0.load_val = load_val;
  assign if0.tick     = tick;
  assign if1.reconfig = reconfig;
  assign if1.load     = load;
  assign if1.load_val = load_val;
  assign if1.tick     = tick;

  digit_timer_n #(.NUM_DIGITS(4), .DIGIT_MAX(16'h5959), .RESET_VAL(16'h5959), .AUTO_RELOAD(1'b0))
    dut0 (.clk(clk), .rst(rst), .tif(if0));
  digit_timer_n #(.NUM_DIGITS(4), .DIGIT_MAX(16'h5959), .RESET_VAL(16'h5959), .AUTO_RELOAD(1'b1))
    dut1 (.clk(clk), .rst(rst), .tif(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: count held as an integer in the mixed radix 6,10,6,10.
  int m_val[2];
  int m_rel[2];
  bit m_done[2];
  bit m_stall[2];

  function automatic int to_int(input logic [15:0] c);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      v += int'(c[4*i +: 4]) * w;
      w *= MAXD[i] + 1;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % (MAXD[i] + 1));
      x = x / (MAXD[i] + 1);
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [15:0] lv);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = (int'(lv[4*i +: 4]) > MAXD[i]) ? 4'(MAXD[i]) : lv[4*i +: 4];
    return to_int(r);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k]   = to_int(16'h5959);
      m_rel[k]   = m_val[k];
      m_done[k]  = 1'b0;
      m_stall[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic r, input logic l, input logic [15:0] v, input logic t);
    for (int k = 0; k < 2; k++) begin
      m_done[k]  = 1'b0;
      m_stall[k] = 1'b0;
      if (r) begin
        m_val[k] = m_rel[k];
      end else if (l) begin
        m_val[k] = clamp_val(v);
        m_rel[k] = m_val[k];
      end else if (t) begin
        if (m_val[k] != 0) begin
          m_val[k]  = m_val[k] - 1;
          m_done[k] = (m_val[k] == 0);
        end else if (k == 1) begin
          m_val[k] = m_rel[k];
        end else begin
          m_stall[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model cnt0",   if0.count, to_bcd(m_val[0]));
    chk("model done0",  if0.done,  m_done[0]);
    chk("model stall0", if0.stall, m_stall[0]);
    chk("model zero0",  if0.zero,  m_val[0] == 0);
    chk("model cnt1",   if1.count, to_bcd(m_val[1]));
    chk("model done1",  if1.done,  m_done[1]);
    chk("model stall1", if1.stall, m_stall[1]);
    chk("model zero1",  if1.zero,  m_val[1] == 0);
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] v, input logic t);
    reconfig = r;
    load     = l;
    load_val = v;
    tick     = t;
    @(posedge clk);
    #1;
    model_step(r, l, v, t);
    check_model();
    reconfig = 1'b0;
    load     = 1'b0;
    tick     = 1'b0;
  endtask

  typedef struct {
    logic        rc;
    logic        ld;
    logic [15:0] lv;
    logic        tk;
    logic [15:0] ec;
    logic        ed;
    logic        es;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic rc, input logic ld, input logic [15:0] lv,
                              input logic tk, input logic [15:0] ec, input logic ed,
                              input logic es);
    vec_t x;
    x.rc = rc; x.ld = ld; x.lv = lv; x.tk = tk; x.ec = ec; x.ed = ed; x.es = es;
    return x;
  endfunction

  initial begin
    // expectations for the AUTO_RELOAD=0 instance
    vecs[0]  = mk(0, 1, 16'h0100, 0, 16'h0100, 0, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h0059, 0, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 1, 16'h0058, 0, 0);
    vecs[3]  = mk(0, 1, 16'h1000, 0, 16'h1000, 0, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 1, 16'h0959, 0, 0);
    vecs[5]  = mk(0, 1, 16'h0002, 0, 16'h0002, 0, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 1, 16'h0001, 0, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 1, 16'h0000, 1, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 16'h0000, 0, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 1, 16'h0000, 0, 1);
    vecs[10] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[11] = mk(0, 1, 16'h7A9F, 0, 16'h5959, 0, 0);
    vecs[12] = mk(0, 1, 16'h0010, 1, 16'h0010, 0, 0);
    vecs[13] = mk(0, 1, 16'h0030, 0, 16'h0030, 0, 0);
    vecs[14] = mk(0, 0, 16'h0000, 1, 16'h0029, 0, 0);
    vecs[15] = mk(0, 0, 16'h0000, 1, 16'h0028, 0, 0);
    vecs[16] = mk(0, 0, 16'h0000, 1, 16'h0027, 0, 0);
    vecs[17] = mk(0, 0, 16'h0000, 1, 16'h0026, 0, 0);
    vecs[18] = mk(0, 0, 16'h0000, 1, 16'h0025, 0, 0);
    vecs[19] = mk(1, 0, 16'h0000, 0, 16'h0030, 0, 0);
    vecs[20] = mk(1, 1, 16'h0005, 1, 16'h0030, 0, 0);
    vecs[21] = mk(0, 0, 16'h0000, 1, 16'h0029, 0, 0);
    vecs[22] = mk(1, 0, 16'h0000, 0, 16'h0030, 0, 0);

    rst      = 1'b0;
    reconfig = 1'b0;
    load     = 1'b0;
    tick     = 1'b0;
    load_val = '0;
    model_reset();
    #12;
    chk("reset cnt0",  if0.count, 16'h5959);
    chk("reset done0", if0.done,  1'b0);
    chk("reset stall0", if0.stall, 1'b0);
    chk("reset cnt1",  if1.count, 16'h5959);
    rst = 1'b1;
    step(0, 0, 16'h0000, 1);
    chk("first tick", if0.count, 16'h5958);

    // async reset mid-count, checked before any further clock edge
    step(0, 1, 16'h0342, 0);
    chk("load 0342", if0.count, 16'h0342);
    rst = 1'b0;
    #2;
    chk("async rst cnt0",   if0.count, 16'h5959);
    chk("async rst done0",  if0.done,  1'b0);
    chk("async rst stall0", if0.stall, 1'b0);
    chk("async rst cnt1",   if1.count, 16'h5959);
    model_reset();
    #1;
    rst = 1'b1;
    step(0, 0, 16'h0000, 0);
    chk("post rst hold", if0.count, 16'h5959);

    foreach (vecs[i]) begin
      step(vecs[i].rc, vecs[i].ld, vecs[i].lv, vecs[i].tk);
      chk($sformatf("vec%0d cnt", i),   if0.count, vecs[i].ec);
      chk($sformatf("vec%0d done", i),  if0.done,  vecs[i].ed);
      chk($sformatf("vec%0d stall", i), if0.stall, vecs[i].es);
      chk($sformatf("vec%0d zero", i),  if0.zero,  vecs[i].ec == 16'h0000);
    end

    // auto-reload expiry and restart
    step(0, 1, 16'h0002, 0);
    step(0, 0, 16'h0000, 1);
    step(0, 0, 16'h0000, 1);
    chk("ar expire cnt",  if1.count, 16'h0000);
    chk("ar expire done", if1.done,  1'b1);
    step(0, 0, 16'h0000, 1);
    chk("ar restart cnt",   if1.count, 16'h0002);
    chk("ar restart done",  if1.done,  1'b0);
    chk("ar restart stall", if1.stall, 1'b0);

    // loading zero expires silently; reload value of zero never pulses
    step(0, 1, 16'h0000, 0);
    chk("load0 done1", if1.done, 1'b0);
    chk("load0 zero1", if1.zero, 1'b1);
    step(0, 0, 16'h0000, 1);
    chk("rel0 cnt1",   if1.count, 16'h0000);
    chk("rel0 done1",  if1.done,  1'b0);
    chk("rel0 stall1", if1.stall, 1'b0);
    chk("rel0 stall0", if0.stall, 1'b1);

    for (int n = 0; n < 800; n++) begin
      logic        r, l, t;
      logic [15:0] v;
      r = ($urandom % 40) == 0;
      l = ($urandom % 10) == 0;
      t = ($urandom % 4) != 0;
      v = ($urandom % 2) ? 16'($urandom) : {8'h00, 8'($urandom)};
      step(r, l, v, t);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/digit_timer_n.md
Name: digit_timer_n

Overview:
- Parametrised multi-digit BCD countdown timer; successor to the single-digit timer cell.
- Holds NUM_DIGITS digits with a per-digit maximum, so mixed radices such as MM:SS are supported.
- Borrow between digits is resolved internally in one cycle.
- Adds load, auto-reload mode, a done pulse and a stall indication.
- Sits between the 1 Hz tick generator and the 7-segment display driver.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; digit 0 is least significant.
- DIGIT_MAX, 16'h5959, packed 4*NUM_DIGITS vector of per-digit maximum values. Each field is 1..9. The default gives MM:SS.
- RESET_VAL, 16'h5959, count and reload value after reset. Each field must be <= its DIGIT_MAX field.
- AUTO_RELOAD, 0, behaviour on a tick at zero: 0 = hold at zero, 1 = restart from the reload value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- reconfig  input  1  synchronous restart: count <= reload value.
- load  input  1  synchronous load of load_val into both count and the reload register.
- load_val  input  4*NUM_DIGITS  BCD value to load.
- tick  input  1  decrement request, one count per cycle it is high.
- count  output  4*NUM_DIGITS  current BCD value, registered.
- zero  output  1  high when count == 0; combinational decode of registered count.
- done  output  1  registered one-cycle pulse on the nonzero-to-zero transition.
- stall  output  1  registered one-cycle pulse when a tick arrives at zero and AUTO_RELOAD=0.

Behaviour:
- Reset (rst=0, asynchronous, no clock required):
  - count = RESET_VAL, reload_q = RESET_VAL, done = 0, stall = 0.
  - Reset asserted mid-count overrides everything immediately.
- Priority per rising edge: reconfig > load > tick > idle.
- reconfig=1:
  - count <= reload_q; done <= 0; stall <= 0.
  - load and tick in the same cycle are ignored; reload_q is unchanged.
- load=1 (reconfig=0):
  - Each digit is clamped to its DIGIT_MAX field: digit_i = min(load_val_i, max_i). Clamping covers non-BCD nibbles A-F.
  - count <= clamped value; reload_q <= clamped value; done <= 0; stall <= 0.
  - A simultaneous tick is ignored.
- tick=1 with count != 0:
  - Digit i decrements if all digits below i are 0.
  - Every digit that is 0 and has a borrow taken through it reloads to max_i.
  - Digits above the first nonzero digit are unchanged.
  - Latency is one edge: the new count is visible the cycle after tick is sampled.
  - done <= 1 if the new count == 0, else 0; stall <= 0.
- tick=1 with count == 0:
  - AUTO_RELOAD=0: count holds 0; stall <= 1; done <= 0.
  - AUTO_RELOAD=1: count <= reload_q; stall <= 0; done <= 0.
  - If reload_q == 0 under AUTO_RELOAD=1, count stays 0 and neither flag pulses.
- Idle (no tick, load or reconfig): count holds; done <= 0; stall <= 0.
  - Both pulses therefore last exactly one cycle.
- Control state machine is implicit in count: RUNNING when count != 0, EXPIRED when count == 0.
  - load or reconfig with a nonzero value returns to RUNNING.
  - Loading 0 enters EXPIRED without a done pulse.
- Width rules:
  - All digit arithmetic is 4-bit modulo within 0..max_i.
  - count never holds a digit above max_i.
  - No carry or borrow leaves the block; stall replaces the old nb_dn chaining output.
- Back-to-back ticks on every cycle are legal: one decrement per cycle, no throughput loss.

Test Plan:
- Async reset: mid-count (count=16'h0342), drive rst=0 between clock edges -> count=16'h5959, done=0, stall=0 before the next edge; release -> holds 5959 with tick=0.
- Borrow chain: load 16'h0100, then tick -> 16'h0059; tick -> 16'h0058. Load 16'h1000, tick -> 16'h0959 (tens-of-seconds field reloads to 5).
- Expiry, AUTO_RELOAD=0: load 16'h0002, ticks on consecutive cycles -> 0001, then 0000 with done=1 and zero=1 for one cycle. Third tick -> 0000, stall=1, done=0. Fourth tick -> stall=1 again.
- AUTO_RELOAD=1: load 16'h0002, two ticks -> 0000 with done=1. Third tick -> 0002, done=0, stall=0.
- Clamping and priority: load 16'h7A9F -> count=16'h5959. Load 16'h0010 with tick=1 in the same cycle -> count=16'h0010 (load wins).
- reconfig: load 16'h0030, tick x5 -> 16'h0025. reconfig -> 16'h0030. reconfig+load(16'h0005)+tick together -> 16'h0030 and reload_q unchanged. A following reconfig -> 16'h0030.
